machine_timer: RTL and testbench

MACHINE_TIMER -- requirements
Module: machine_timer

---
 rtl/machine_timer.sv | 87 ++++++++
 tb/tb_machine_timer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/machine_timer.sv
// Memory-mapped machine timer: 64-bit mtime/mtimecmp with prescaler, registered mtip.
// Reads and faults respond one cycle after the access; accepts one access per cycle, never stalls.
module machine_timer #(
  parameter int unsigned PRESCALE  = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_8004
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_type,
  input  logic [31:0] mem_wdata,
  output logic        mem_hit,
  output logic [31:0] mem_rdata,
  output logic        mem_rvalid,
  output logic        mem_afault,
  output logic        mtip
);

  localparam logic [3:0]  MEM_LW        = 4'b1010;
  localparam logic [3:0]  MEM_SW        = 4'b1110;
  localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);

  logic [63:0] mtime, mtime_nxt;
  logic [63:0] mtimecmp, mtimecmp_nxt;
  logic [15:0] prescale_cnt;
  logic [31:0] mtime_high_shadow;
  logic [29:0] word_off;
  logic [1:0]  word_sel;
  logic        legal, do_load, do_store, tick;

  // BASE_ADDR is only word aligned, so decode by word offset rather than a fixed 16-byte block.
  assign word_off = mem_addr[31:2] - BASE_ADDR[31:2];
  assign word_sel = word_off[1:0];
  assign mem_hit  = mem_type[3] && (word_off < 30'd4);
  assign legal    = mem_hit && (mem_addr[1:0] == 2'b00) &&
                    ((mem_type == MEM_LW) || (mem_type == MEM_SW));
  assign do_load  = legal && (mem_type == MEM_LW);
  assign do_store = legal && (mem_type == MEM_SW);
  assign tick     = (prescale_cnt == PRESCALE_LAST);

  always_comb begin
    mtime_nxt    = tick ? (mtime + 64'd1) : mtime;
    mtimecmp_nxt = mtimecmp;
    if (do_store) begin
      // An mtime store overrides this cycle's increment so software sees exactly what it wrote.
      case (word_sel)
        2'd0: mtime_nxt    = {mtime[63:32], mem_wdata};
        2'd1: mtime_nxt    = {mem_wdata, mtime[31:0]};
        2'd2: mtimecmp_nxt = {mtimecmp[63:32], mem_wdata};
        2'd3: mtimecmp_nxt = {mem_wdata, mtimecmp[31:0]};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mtime             <= 64'd0;
      mtimecmp          <= 64'hFFFF_FFFF_FFFF_FFFF;
      prescale_cnt      <= 16'd0;
      mtime_high_shadow <= 32'd0;
      mem_rdata         <= 32'd0;
      mem_rvalid        <= 1'b0;
      mem_afault        <= 1'b0;
      mtip              <= 1'b0;
    end else begin
      prescale_cnt <= tick ? 16'd0 : (prescale_cnt + 16'd1);
      mtime        <= mtime_nxt;
      mtimecmp     <= mtimecmp_nxt;
      mtip         <= (mtime_nxt >= mtimecmp_nxt);
      mem_rvalid   <= do_load;
      mem_afault   <= mem_hit && !legal;
      if (do_load) begin
        // Reading the low half snapshots the high half so a 32-bit reader sees a consistent pair.
        case (word_sel)
          2'd0: begin
            mem_rdata         <= mtime[31:0];
            mtime_high_shadow <= mtime[63:32];
          end
          2'd1: mem_rdata <= mtime_high_shadow;
          2'd2: mem_rdata <= mtimecmp[31:0];
          2'd3: mem_rdata <= mtimecmp[63:32];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_machine_timer.sv
// Self-checking bench for machine_timer: PRESCALE=1 and PRESCALE=4 instances, scoreboarded reads.
module tb_machine_timer;

  localparam logic [31:0] B       = 32'h0000_8004;
  localparam logic [31:0] MTL     = B;
  localparam logic [31:0] MTH     = B + 32'd4;
  localparam logic [31:0] CL      = B + 32'd8;
  localparam logic [31:0] CH      = B + 32'd12;
  localparam logic [3:0]  MEM_LW  = 4'b1010;
  localparam logic [3:0]  MEM_SW  = 4'b1110;
  localparam logic [3:0]  MEM_NOP = 4'b0000;
  localparam logic [3:0]  MEM_LB  = 4'b1000;
  localparam logic [3:0]  MEM_SB  = 4'b1100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_type;
  logic        tgt;
  logic [3:0]  type1, type4;
  logic        hit1, rvalid1, afault1, mtip1;
  logic        hit4, rvalid4, afault4, mtip4;
  logic [31:0] rdata1, rdata4;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] q1[$];
  logic [31:0] q4[$];

  always #5 clk = ~clk;

  assign type1 = (tgt == 1'b0) ? mem_type : MEM_NOP;
  assign type4 = (tgt == 1'b1) ? mem_type : MEM_NOP;

  machine_timer #(.PRESCALE(1), .BASE_ADDR(B)) u1 (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_type(type1), .mem_wdata(mem_wdata),
    .mem_hit(hit1), .mem_rdata(rdata1), .mem_rvalid(rvalid1), .mem_afault(afault1), .mtip(mtip1)
  );

  machine_timer #(.PRESCALE(4), .BASE_ADDR(B)) u4 (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_type(type4), .mem_wdata(mem_wdata),
    .mem_hit(hit4), .mem_rdata(rdata4), .mem_rvalid(rvalid4), .mem_afault(afault4), .mtip(mtip4)
  );

  // Scoreboard: every rvalid pulse must match the oldest expected read of that instance.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rvalid1 === 1'b1) begin
      n_cmp++;
      if (q1.size() == 0) begin
        n_err++;
        $display("FAIL rd_p1 unexpected rvalid rdata=%h required no rvalid", rdata1);
      end else begin
        e = q1.pop_front();
        if (rdata1 !== e) begin
          n_err++;
          $display("FAIL rd_p1 rdata=%h required %h", rdata1, e);
        end
      end
    end
    if (rvalid4 === 1'b1) begin
      n_cmp++;
      if (q4.size() == 0) begin
        n_err++;
        $display("FAIL rd_p4 unexpected rvalid rdata=%h required no rvalid", rdata4);
      end else begin
        e = q4.pop_front();
        if (rdata4 !== e) begin
          n_err++;
          $display("FAIL rd_p4 rdata=%h required %h", rdata4, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  task automatic issue(input logic [31:0] a, input logic [3:0] t, input logic [31:0] d);
    mem_addr  = a;
    mem_type  = t;
    mem_wdata = d;
    @(negedge clk);
    mem_type  = MEM_NOP;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] exp);
    if (tgt) q4.push_back(exp);
    else     q1.push_back(exp);
    issue(a, MEM_LW, 32'd0);
  endtask

  task automatic idle(input int n);
    mem_type = MEM_NOP;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    mem_type = MEM_NOP;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
  endtask

  task automatic test_reset();
    tgt   = 1'b0;
    rst_n = 1'b1;
    issue(CL, MEM_SW, 32'd5);
    issue(CH, MEM_SW, 32'd0);
    idle(8);
    load(CL, 32'd5);
    n_cmp++;
    if (mtip1 !== 1'b1) begin n_err++; $display("FAIL pre_reset_mtip mtip=%b required 1", mtip1); end
    do_reset();
    n_cmp++;
    if (mtip1 !== 1'b0) begin n_err++; $display("FAIL reset_mtip mtip=%b required 0", mtip1); end
    n_cmp++;
    if (rdata1 !== 32'd0) begin n_err++; $display("FAIL reset_rdata rdata=%h required 0", rdata1); end
    n_cmp++;
    if (rvalid1 !== 1'b0 || afault1 !== 1'b0) begin
      n_err++; $display("FAIL reset_pulses rvalid=%b afault=%b required 0 0", rvalid1, afault1);
    end
    load(MTL, 32'd0);
    load(MTL, 32'd1);
    load(MTH, 32'd0);
    load(CL, 32'hFFFF_FFFF);
    load(CH, 32'hFFFF_FFFF);
  endtask

  task automatic test_decode();
    logic [31:0] a_tab[7] = '{B, CH, B + 32'd16, B - 32'd4, CL, MTH, B + 32'd3};
    logic [3:0]  t_tab[7] = '{MEM_LW, MEM_SW, MEM_LW, MEM_LW, MEM_NOP, MEM_LB, MEM_LW};
    logic        h_tab[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tgt = 1'b0;
    for (int i = 0; i < 7; i++) begin
      mem_addr = a_tab[i];
      mem_type = t_tab[i];
      #1;
      n_cmp++;
      if (hit1 !== h_tab[i]) begin
        n_err++; $display("FAIL decode_%0d mem_hit=%b required %b", i, hit1, h_tab[i]);
      end
      mem_type = MEM_NOP;
      @(negedge clk);
    end
  endtask

  task automatic test_count_compare();
    tgt = 1'b0;
    do_reset();
    issue(CL, MEM_SW, 32'd10);
    issue(CH, MEM_SW, 32'd0);
    n_cmp++;
    if (mtip1 !== 1'b0) begin n_err++; $display("FAIL cmp_early mtip=%b required 0", mtip1); end
    idle(7);
    n_cmp++;
    if (mtip1 !== 1'b0) begin n_err++; $display("FAIL cmp_at9 mtip=%b required 0", mtip1); end
    idle(1);
    n_cmp++;
    if (mtip1 !== 1'b1) begin n_err++; $display("FAIL cmp_at10 mtip=%b required 1", mtip1); end
    load(MTL, 32'd10);
    n_cmp++;
    if (mtip1 !== 1'b1) begin n_err++; $display("FAIL cmp_level mtip=%b required 1", mtip1); end
    issue(CL, MEM_SW, 32'd100);
    n_cmp++;
    if (mtip1 !== 1'b0) begin n_err++; $display("FAIL cmp_clear mtip=%b required 0", mtip1); end
  endtask

  task automatic test_wrap();
    tgt = 1'b0;
    do_reset();
    issue(MTH, MEM_SW, 32'hFFFF_FFFF);
    issue(MTL, MEM_SW, 32'hFFFF_FFFE);
    n_cmp++;
    if (mtip1 !== 1'b0) begin n_err++; $display("FAIL wrap_mtip_fe mtip=%b required 0", mtip1); end
    load(MTL, 32'hFFFF_FFFE);
    n_cmp++;
    if (mtip1 !== 1'b1) begin n_err++; $display("FAIL wrap_mtip_ff mtip=%b required 1", mtip1); end
    load(MTL, 32'hFFFF_FFFF);
    n_cmp++;
    if (mtip1 !== 1'b0) begin n_err++; $display("FAIL wrap_mtip_0 mtip=%b required 0", mtip1); end
    load(MTL, 32'd0);
    load(MTH, 32'd0);
  endtask

  task automatic test_atomic();
    tgt = 1'b0;
    do_reset();
    issue(MTH, MEM_SW, 32'd1);
    issue(MTL, MEM_SW, 32'hFFFF_FFFF);
    load(MTL, 32'hFFFF_FFFF);
    idle(2);
    load(MTH, 32'd1);
    idle(1);
    n_cmp++;
    if (rdata1 !== 32'd1) begin n_err++; $display("FAIL rdata_hold rdata=%h required 1", rdata1); end
    load(MTL, 32'd4);
    load(MTH, 32'd2);
  endtask

  task automatic test_faults();
    tgt = 1'b0;
    do_reset();
    issue(CL, MEM_SW, 32'h55);
    n_cmp++;
    if (afault1 !== 1'b0) begin n_err++; $display("FAIL fault_legal_sw afault=%b required 0", afault1); end
    issue(B, MEM_LB, 32'd0);
    n_cmp++;
    if (afault1 !== 1'b1 || rvalid1 !== 1'b0) begin
      n_err++; $display("FAIL fault_lb afault=%b rvalid=%b required 1 0", afault1, rvalid1);
    end
    issue(B + 32'd2, MEM_LW, 32'd0);
    n_cmp++;
    if (afault1 !== 1'b1 || rvalid1 !== 1'b0) begin
      n_err++; $display("FAIL fault_lw_misal afault=%b rvalid=%b required 1 0", afault1, rvalid1);
    end
    issue(CL + 32'd1, MEM_SW, 32'hAA);
    n_cmp++;
    if (afault1 !== 1'b1) begin n_err++; $display("FAIL fault_sw_misal afault=%b required 1", afault1); end
    issue(CH, MEM_SB, 32'hBB);
    n_cmp++;
    if (afault1 !== 1'b1) begin n_err++; $display("FAIL fault_sb afault=%b required 1", afault1); end
    idle(1);
    n_cmp++;
    if (afault1 !== 1'b0) begin n_err++; $display("FAIL fault_pulse afault=%b required 0", afault1); end
    load(CL, 32'h55);
    load(CH, 32'hFFFF_FFFF);
  endtask

  task automatic test_prescale();
    logic [31:0] after_tab[7] = '{32'd5, 32'd5, 32'd6, 32'd6, 32'd6, 32'd6, 32'd7};
    tgt = 1'b1;
    do_reset();
    for (int i = 0; i < 9; i++) load(MTL, 32'(i / 4));
    issue(MTL, MEM_SW, 32'd5);
    for (int i = 0; i < 7; i++) load(MTL, after_tab[i]);
    tgt = 1'b0;
  endtask

  task automatic test_reset_mid();
    tgt = 1'b0;
    do_reset();
    issue(CL, MEM_SW, 32'd3);
    issue(CH, MEM_SW, 32'd0);
    idle(6);
    n_cmp++;
    if (mtip1 !== 1'b1) begin n_err++; $display("FAIL rstmid_pre mtip=%b required 1", mtip1); end
    mem_addr = MTL;
    mem_type = MEM_LW;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    mem_type = MEM_NOP;
    n_cmp++;
    if (rvalid1 !== 1'b0 || afault1 !== 1'b0) begin
      n_err++; $display("FAIL rstmid_pulse rvalid=%b afault=%b required 0 0", rvalid1, afault1);
    end
    n_cmp++;
    if (mtip1 !== 1'b0) begin n_err++; $display("FAIL rstmid_mtip mtip=%b required 0", mtip1); end
    load(MTL, 32'd0);
    load(CL, 32'hFFFF_FFFF);
    load(CH, 32'hFFFF_FFFF);
    n_cmp++;
    if (mtip1 !== 1'b0) begin n_err++; $display("FAIL rstmid_after mtip=%b required 0", mtip1); end
  endtask

  initial begin
    rst_n     = 1'b0;
    tgt       = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_type  = MEM_NOP;
    repeat (2) @(negedge clk);
    test_reset();
    test_decode();
    test_count_compare();
    test_wrap();
    test_atomic();
    test_faults();
    test_prescale();
    test_reset_mid();
    idle(3);
    n_cmp++;
    if (q1.size() != 0) begin n_err++; $display("FAIL missing_rd_p1 pending=%0d required 0", q1.size()); end
    n_cmp++;
    if (q4.size() != 0) begin n_err++; $display("FAIL missing_rd_p4 pending=%0d required 0", q4.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
